basic_control_unit: RTL and testbench

Hardwired control unit for the 16-bit basic computer; sits directly upstream of `datapath` and drives every one of its control inputs. Sequences fetch, decode, indirect-address and execute phases with a timing counter (T0..T6), decoding IR, AC, DR and E fed back from the datapath. It covers all memory-reference, register-reference and ION/IOF instructions, and stops in a halt state on HLT.

---
 rtl/basic_control_unit.sv | 212 +++++++++++++++++++++
 tb/tb_basic_control_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/basic_control_unit.sv
// Hardwired control unit for the 16-bit basic computer: sequences fetch, decode,
// indirect and execute steps and decodes every datapath strobe from state and step.
module basic_control_unit #(
    parameter int WIDTH          = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] IR,
    input  logic [WIDTH-1:0] AC,
    input  logic [WIDTH-1:0] DR,
    input  logic             E,
    output logic [2:0]       bus_select,
    output logic [2:0]       alu_select,
    output logic             write_En,
    output logic             clr_AC,
    output logic             clr_E,
    output logic             clr_AR,
    output logic             clr_PC,
    output logic             comp_E,
    output logic             ldr_AR,
    output logic             ldr_PC,
    output logic             ldr_IR,
    output logic             ldr_DR,
    output logic             ldr_AC,
    output logic             ldr_TR,
    output logic             inc_AR,
    output logic             inc_AC,
    output logic             inc_DR,
    output logic             inc_PC,
    output logic             set_IEN,
    output logic             clr_IEN,
    output logic [2:0]       sc,
    output logic             halted
);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_HALT} state_t;

    state_t     state;
    logic [2:0] step;
    logic [2:0] d;
    logic       ind;
    logic       last_step;
    logic       hlt;

    assign d   = IR[14:12];
    assign ind = IR[15];
    assign sc  = step;
    assign hlt = (state == S_RUN) && (step == 3'd3) && (d == 3'd7) && !ind
                 && (IR[11:0] == 12'h001);

    always_comb begin
        last_step = 1'b0;
        if (d == 3'd7) begin
            last_step = (step == 3'd3);
        end else begin
            case (d)
                3'd3, 3'd4: last_step = (step == 3'd4);
                3'd6:       last_step = (step == 3'd6);
                default:    last_step = (step == 3'd5);
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_INIT;
            step   <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    state <= S_RUN;
                    step  <= '0;
                end
                S_RUN: begin
                    if (last_step) begin
                        step <= '0;
                        if (hlt) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: begin
                    step   <= '0;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    // Strobes are gated by rst itself so they drop the instant reset is asserted.
    always_comb begin
        bus_select = '0;
        alu_select = '0;
        write_En   = 1'b0;
        clr_AC     = 1'b0;
        clr_E      = 1'b0;
        clr_AR     = 1'b0;
        clr_PC     = 1'b0;
        comp_E     = 1'b0;
        ldr_AR     = 1'b0;
        ldr_PC     = 1'b0;
        ldr_IR     = 1'b0;
        ldr_DR     = 1'b0;
        ldr_AC     = 1'b0;
        ldr_TR     = 1'b0;
        inc_AR     = 1'b0;
        inc_AC     = 1'b0;
        inc_DR     = 1'b0;
        inc_PC     = 1'b0;
        set_IEN    = 1'b0;
        clr_IEN    = 1'b0;
        if (!rst && state == S_INIT && CLEAR_ON_RESET) begin
            clr_AC = 1'b1;
            clr_E  = 1'b1;
            clr_AR = 1'b1;
            clr_PC = 1'b1;
        end else if (!rst && state == S_RUN) begin
            case (step)
                3'd0: begin
                    bus_select = 3'd2;
                    ldr_AR     = 1'b1;
                end
                3'd1: begin
                    bus_select = 3'd7;
                    ldr_IR     = 1'b1;
                    inc_PC     = 1'b1;
                end
                3'd2: begin
                    bus_select = 3'd5;
                    ldr_AR     = 1'b1;
                end
                3'd3: begin
                    if (d != 3'd7) begin
                        if (ind) begin
                            bus_select = 3'd7;
                            ldr_AR     = 1'b1;
                        end
                    end else if (ind) begin
                        if (IR[7])      set_IEN = 1'b1;
                        else if (IR[6]) clr_IEN = 1'b1;
                    end else begin
                        // Only the most significant set bit of the operand field acts.
                        casez (IR[11:0])
                            12'b1???_????_????: clr_AC = 1'b1;
                            12'b01??_????_????: clr_E  = 1'b1;
                            12'b001?_????_????: begin alu_select = 3'd3; ldr_AC = 1'b1; end
                            12'b0001_????_????: comp_E = 1'b1;
                            12'b0000_1???_????: begin alu_select = 3'd5; ldr_AC = 1'b1; end
                            12'b0000_01??_????: begin alu_select = 3'd6; ldr_AC = 1'b1; end
                            12'b0000_001?_????: inc_AC = 1'b1;
                            12'b0000_0001_????: inc_PC = !AC[WIDTH-1];
                            12'b0000_0000_1???: inc_PC = AC[WIDTH-1];
                            12'b0000_0000_01??: inc_PC = (AC == '0);
                            12'b0000_0000_001?: inc_PC = !E;
                            default: ;
                        endcase
                    end
                end
                3'd4: begin
                    case (d)
                        3'd0, 3'd1, 3'd2, 3'd6: begin
                            bus_select = 3'd7;
                            ldr_DR     = 1'b1;
                        end
                        3'd3: begin
                            bus_select = 3'd4;
                            write_En   = 1'b1;
                        end
                        3'd4: begin
                            bus_select = 3'd1;
                            ldr_PC     = 1'b1;
                        end
                        3'd5: begin
                            bus_select = 3'd2;
                            write_En   = 1'b1;
                            inc_AR     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd5: begin
                    case (d)
                        3'd0, 3'd1, 3'd2: begin
                            alu_select = d;
                            ldr_AC     = 1'b1;
                        end
                        3'd5: begin
                            bus_select = 3'd1;
                            ldr_PC     = 1'b1;
                        end
                        3'd6: inc_DR = 1'b1;
                        default: ;
                    endcase
                end
                3'd6: begin
                    if (d == 3'd6) begin
                        bus_select = 3'd3;
                        write_En   = 1'b1;
                        inc_PC     = (DR == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_basic_control_unit.sv
// Bench for basic_control_unit: directed table, hand sequences for reset/halt,
// and random instructions compared against an instruction-level expansion model.
module tb_basic_control_unit;

    typedef struct packed {
        logic [2:0] bus;
        logic [2:0] alu;
        logic write_En, clr_AC, clr_E, clr_AR, clr_PC, comp_E, ldr_AR, ldr_PC, ldr_IR;
        logic ldr_DR, ldr_AC, ldr_TR, inc_AR, inc_AC, inc_DR, inc_PC, set_IEN, clr_IEN;
        logic [2:0] sc;
        logic halted;
    } outs_t;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] ac;
        logic [15:0] dr;
        logic        e;
        int          cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] IR = '0, AC = '0, DR = '0;
    logic        E = 1'b0;

    logic [2:0] bus1, alu1, sc1, bus0, alu0, sc0;
    logic we1, cac1, ce1, car1, cpc1, cme1, lar1, lpc1, lir1, ldr1, lac1, ltr1;
    logic iar1, iac1, idr1, ipc1, sien1, cien1, h1;
    logic we0, cac0, ce0, car0, cpc0, cme0, lar0, lpc0, lir0, ldr0, lac0, ltr0;
    logic iar0, iac0, idr0, ipc0, sien0, cien0, h0;

    outs_t act, act0;
    outs_t exq[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    basic_control_unit #(.WIDTH(16), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst(rst), .IR(IR), .AC(AC), .DR(DR), .E(E),
        .bus_select(bus1), .alu_select(alu1), .write_En(we1), .clr_AC(cac1), .clr_E(ce1),
        .clr_AR(car1), .clr_PC(cpc1), .comp_E(cme1), .ldr_AR(lar1), .ldr_PC(lpc1),
        .ldr_IR(lir1), .ldr_DR(ldr1), .ldr_AC(lac1), .ldr_TR(ltr1), .inc_AR(iar1),
        .inc_AC(iac1), .inc_DR(idr1), .inc_PC(ipc1), .set_IEN(sien1), .clr_IEN(cien1),
        .sc(sc1), .halted(h1)
    );

    basic_control_unit #(.WIDTH(16), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .rst(rst), .IR(IR), .AC(AC), .DR(DR), .E(E),
        .bus_select(bus0), .alu_select(alu0), .write_En(we0), .clr_AC(cac0), .clr_E(ce0),
        .clr_AR(car0), .clr_PC(cpc0), .comp_E(cme0), .ldr_AR(lar0), .ldr_PC(lpc0),
        .ldr_IR(lir0), .ldr_DR(ldr0), .ldr_AC(lac0), .ldr_TR(ltr0), .inc_AR(iar0),
        .inc_AC(iac0), .inc_DR(idr0), .inc_PC(ipc0), .set_IEN(sien0), .clr_IEN(cien0),
        .sc(sc0), .halted(h0)
    );

    assign act  = {bus1, alu1, we1, cac1, ce1, car1, cpc1, cme1, lar1, lpc1, lir1,
                   ldr1, lac1, ltr1, iar1, iac1, idr1, ipc1, sien1, cien1, sc1, h1};
    assign act0 = {bus0, alu0, we0, cac0, ce0, car0, cpc0, cme0, lar0, lpc0, lir0,
                   ldr0, lac0, ltr0, iar0, iac0, idr0, ipc0, sien0, cien0, sc0, h0};

    function automatic outs_t blank(input logic [2:0] s);
        outs_t r = '0;
        r.sc = s;
        return r;
    endfunction

    // Expands one instruction into the list of per-cycle outputs it should produce.
    function automatic void model(input logic [15:0] ir, input logic [15:0] ac,
                                  input logic [15:0] dr, input logic e);
        outs_t r;
        int    op;
        int    hb;
        exq.delete();
        r = blank(3'd0); r.bus = 3'd2; r.ldr_AR = 1'b1; exq.push_back(r);
        r = blank(3'd1); r.bus = 3'd7; r.ldr_IR = 1'b1; r.inc_PC = 1'b1; exq.push_back(r);
        r = blank(3'd2); r.bus = 3'd5; r.ldr_AR = 1'b1; exq.push_back(r);
        op = int'(ir[14:12]);
        r = blank(3'd3);
        if (op == 7) begin
            if (ir[15]) begin
                if (ir[7])      r.set_IEN = 1'b1;
                else if (ir[6]) r.clr_IEN = 1'b1;
            end else begin
                hb = -1;
                for (int b = 0; b < 12; b++) if (ir[b]) hb = b;
                case (hb)
                    11: r.clr_AC = 1'b1;
                    10: r.clr_E  = 1'b1;
                    9:  begin r.alu = 3'd3; r.ldr_AC = 1'b1; end
                    8:  r.comp_E = 1'b1;
                    7:  begin r.alu = 3'd5; r.ldr_AC = 1'b1; end
                    6:  begin r.alu = 3'd6; r.ldr_AC = 1'b1; end
                    5:  r.inc_AC = 1'b1;
                    4:  r.inc_PC = (ac < 16'h8000);
                    3:  r.inc_PC = (ac >= 16'h8000);
                    2:  r.inc_PC = (ac == 16'd0);
                    1:  r.inc_PC = (e == 1'b0);
                    default: ;
                endcase
            end
            exq.push_back(r);
            return;
        end
        if (ir[15]) begin r.bus = 3'd7; r.ldr_AR = 1'b1; end
        exq.push_back(r);
        case (op)
            0, 1, 2: begin
                r = blank(3'd4); r.bus = 3'd7; r.ldr_DR = 1'b1; exq.push_back(r);
                r = blank(3'd5); r.alu = 3'(op); r.ldr_AC = 1'b1; exq.push_back(r);
            end
            3: begin
                r = blank(3'd4); r.bus = 3'd4; r.write_En = 1'b1; exq.push_back(r);
            end
            4: begin
                r = blank(3'd4); r.bus = 3'd1; r.ldr_PC = 1'b1; exq.push_back(r);
            end
            5: begin
                r = blank(3'd4); r.bus = 3'd2; r.write_En = 1'b1; r.inc_AR = 1'b1; exq.push_back(r);
                r = blank(3'd5); r.bus = 3'd1; r.ldr_PC = 1'b1; exq.push_back(r);
            end
            default: begin
                r = blank(3'd4); r.bus = 3'd7; r.ldr_DR = 1'b1; exq.push_back(r);
                r = blank(3'd5); r.inc_DR = 1'b1; exq.push_back(r);
                r = blank(3'd6); r.bus = 3'd3; r.write_En = 1'b1; r.inc_PC = (dr == 16'd0);
                exq.push_back(r);
            end
        endcase
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // Called at the falling edge of a T0 cycle; returns at the falling edge of the next one.
    task automatic run_instr(input logic [15:0] ir, input logic [15:0] ac,
                             input logic [15:0] dr, input logic e);
        IR = ir; AC = ac; DR = dr; E = e;
        #1;
        model(ir, ac, dr, e);
        foreach (exq[k]) begin
            check($sformatf("ir%04h_step%0d", ir, k), act, exq[k]);
            @(negedge clk);
        end
    endtask

    task automatic run_len(input logic [15:0] ir, input logic [15:0] ac,
                           input logic [15:0] dr, input logic e, input int cycles);
        int n = 0;
        IR = ir; AC = ac; DR = dr; E = e;
        do begin
            @(negedge clk);
            n++;
        end while (sc1 != 3'd0 && n < 12);
        check_int($sformatf("len_ir%04h", ir), n, cycles);
    endtask

    // Called between edges; ends at the falling edge of the first T0.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_zero", act, blank(3'd0));
        check("rst_zero_noclr", act0, blank(3'd0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        begin
            outs_t r = blank(3'd0);
            r.clr_AC = 1'b1; r.clr_E = 1'b1; r.clr_AR = 1'b1; r.clr_PC = 1'b1;
            check("init_clear", act, r);
        end
        check("init_noclear", act0, blank(3'd0));
        @(negedge clk);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{16'h1005, 16'h1234, 16'h0000, 1'b0, 6});
        vecs.push_back('{16'hE010, 16'h0000, 16'h0000, 1'b0, 7});
        vecs.push_back('{16'hE010, 16'h0000, 16'h0004, 1'b0, 7});
        vecs.push_back('{16'h7840, 16'h0001, 16'h0000, 1'b1, 4});
        vecs.push_back('{16'h7002, 16'h0000, 16'h0000, 1'b0, 4});
        vecs.push_back('{16'h7002, 16'h0000, 16'h0000, 1'b1, 4});
        vecs.push_back('{16'hF080, 16'h0000, 16'h0000, 1'b0, 4});
        vecs.push_back('{16'hF040, 16'h0000, 16'h0000, 1'b0, 4});
        vecs.push_back('{16'hF800, 16'h0000, 16'h0000, 1'b0, 4});
        vecs.push_back('{16'h0123, 16'h00FF, 16'h0000, 1'b0, 6});
        vecs.push_back('{16'hA123, 16'h00FF, 16'h0000, 1'b0, 6});
        vecs.push_back('{16'h3123, 16'h00FF, 16'h0000, 1'b0, 5});
        vecs.push_back('{16'hC123, 16'h00FF, 16'h0000, 1'b0, 5});
        vecs.push_back('{16'h5010, 16'h00FF, 16'h0000, 1'b0, 6});
        vecs.push_back('{16'h6010, 16'h0000, 16'h0001, 1'b0, 7});
        vecs.push_back('{16'h7010, 16'h8000, 16'h0000, 1'b0, 4});
        vecs.push_back('{16'h7008, 16'h8000, 16'h0000, 1'b0, 4});
        vecs.push_back('{16'h7004, 16'h0000, 16'h0000, 1'b0, 4});
        vecs.push_back('{16'h7200, 16'h5555, 16'h0000, 1'b0, 4});
        vecs.push_back('{16'h7000, 16'h0000, 16'h0000, 1'b0, 4});

        @(negedge clk);
        do_reset();

        foreach (vecs[i]) begin
            run_instr(vecs[i].ir, vecs[i].ac, vecs[i].dr, vecs[i].e);
            run_len(vecs[i].ir, vecs[i].ac, vecs[i].dr, vecs[i].e, vecs[i].cycles);
        end

        // Reset asserted at T5 of ADD: strobes must vanish without waiting for a clock edge.
        IR = 16'h1005;
        repeat (5) @(negedge clk);
        check_int("add_t5_sc", int'(sc1), 5);
        check_int("add_t5_alu", int'(alu1), 1);
        do_reset();
        run_instr(16'h2040, 16'h0000, 16'h0000, 1'b0);

        // HLT parks the unit until reset.
        run_instr(16'h7001, 16'h0000, 16'h0000, 1'b0);
        begin
            outs_t hr = blank(3'd0);
            hr.halted = 1'b1;
            for (int c = 0; c < 20; c++) begin
                IR = 16'(c * 16'h0F31);
                #1 check($sformatf("halt_c%0d", c), act, hr);
                @(negedge clk);
            end
        end
        do_reset();
        run_instr(16'h1005, 16'h0000, 16'h0000, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [15:0] ir, ac, dr;
            ir = 16'($urandom);
            if (ir[14:12] == 3'd7 && $urandom_range(0, 1) == 1) ir[11:0] = 12'(1 << $urandom_range(0, 11));
            if (ir[15:12] == 4'h7 && ir[11:0] == 12'h001) ir[1] = 1'b1;
            ac = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            dr = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
            run_instr(ir, ac, dr, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
